// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: default servo timing constants and counter width helper
package servo_pwm_pkg;
  localparam int CLK_HZ           = 12_000_000;
  localparam int DEF_PRESCALE     = 120;
  localparam int DEF_PERIOD_TICKS = 2000;
  localparam int DEF_MIN_TICKS    = 100;
  localparam int DEF_SPAN_TICKS   = 100;
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/servo_pwm_multi_timebase.sv
// pwm_timebase: shared prescaler and frame counter producing tick and frame boundary
module pwm_timebase
  import servo_pwm_pkg::*;
#(
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
  localparam int PW = cnt_w(PRESCALE - 1),
  localparam int FW = cnt_w(PERIOD_TICKS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          tick_o,
  output logic          fb_o,
  output logic [FW-1:0] frm_cnt_o
);
  logic [PW-1:0] pre_q;
  logic [FW-1:0] frm_q;
  assign tick_o    = pre_q == PW'(PRESCALE - 1);
  assign fb_o      = tick_o && frm_q == FW'(PERIOD_TICKS - 1);
  assign frm_cnt_o = frm_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      frm_q <= '0;
    end else begin
      pre_q <= tick_o ? '0 : pre_q + 1'b1;
      if (tick_o) frm_q <= fb_o ? '0 : frm_q + 1'b1;
    end
  end
endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: N-channel servo PWM with frame-synchronous duty, enable and optional slew
module servo_pwm_multi
  import servo_pwm_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DC_W         = 7,
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
  parameter int MIN_TICKS    = DEF_MIN_TICKS,
  parameter int SPAN_TICKS   = DEF_SPAN_TICKS,
  parameter int SLEW_STEP    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      en,
  input  logic [N_CH-1:0]      invert,
  input  logic [N_CH*DC_W-1:0] dc_in,
  input  logic [N_CH-1:0]      dc_load,
  output logic [N_CH-1:0]      pwm_out,
  output logic                 frame_start
);
  localparam int TW = (DC_W > cnt_w(SPAN_TICKS)) ? DC_W : cnt_w(SPAN_TICKS);
  localparam int CW = cnt_w(PERIOD_TICKS);
  if (MIN_TICKS + SPAN_TICKS > PERIOD_TICKS || PRESCALE < 1 || N_CH < 1) begin : g_bad_params
    $fatal(1, "servo_pwm_multi: invalid parameter set");
  end
  logic          tick, fb_raw, fb, frame_start_q;
  logic [CW-1:0] frm_cnt;
  logic [N_CH-1:0] act;
  pwm_timebase #(
    .PRESCALE    (PRESCALE),
    .PERIOD_TICKS(PERIOD_TICKS)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .tick_o   (tick),
    .fb_o     (fb_raw),
    .frm_cnt_o(frm_cnt)
  );
  assign fb = tick & fb_raw;
  always_ff @(posedge clk) begin
    if (rst) frame_start_q <= 1'b0;
    else     frame_start_q <= fb;
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [TW-1:0] slice, target_q, target_d, app_q, app_d;
    logic          en_app_q, act_q, act_d;
    assign slice = TW'(dc_in[i*DC_W +: DC_W]);
    always_comb begin
      target_d = dc_load[i] ? ((slice > TW'(SPAN_TICKS)) ? TW'(SPAN_TICKS) : slice) : target_q;
      act_d    = en_app_q && (frm_cnt < CW'(MIN_TICKS) + CW'(app_q));
    end
    if (SLEW_STEP == 0) begin : g_direct
      always_comb app_d = target_q;
    end else begin : g_slew
      logic [TW-1:0] up, dn;
      always_comb begin
        up    = target_q - app_q;
        dn    = app_q - target_q;
        app_d = (target_q > app_q)
              ? ((32'(up) > SLEW_STEP) ? app_q + TW'(SLEW_STEP) : target_q)
              : ((32'(dn) > SLEW_STEP) ? app_q - TW'(SLEW_STEP) : target_q);
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        target_q <= '0;
        app_q    <= '0;
        en_app_q <= 1'b0;
        act_q    <= 1'b0;
      end else begin
        target_q <= target_d;
        act_q    <= act_d;
        if (fb) begin
          app_q    <= app_d;
          en_app_q <= en[i];
        end
      end
    end
    assign act[i] = act_q;
  end
  assign pwm_out     = act ^ invert;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: directed checks of frame timing, clamp, slew, polarity and reset
module tb_servo_pwm_multi;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] en = '0, invert = '0, dc_load = '0, dc_load_s = '0;
  logic [5:0] dc_in = '0;
  logic [1:0] pwm, pwm_s;
  logic       fs, fs_s;
  int errors = 0, checks = 0;
  int w0, r0, w1, ws;
  always #5 clk = ~clk;
  servo_pwm_multi #(
    .N_CH(2), .DC_W(3), .PRESCALE(2), .PERIOD_TICKS(10),
    .MIN_TICKS(2), .SPAN_TICKS(4), .SLEW_STEP(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .invert(invert), .dc_in(dc_in),
    .dc_load(dc_load), .pwm_out(pwm), .frame_start(fs)
  );
  servo_pwm_multi #(
    .N_CH(2), .DC_W(3), .PRESCALE(2), .PERIOD_TICKS(10),
    .MIN_TICKS(2), .SPAN_TICKS(4), .SLEW_STEP(1)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en), .invert(invert), .dc_in(dc_in),
    .dc_load(dc_load_s), .pwm_out(pwm_s), .frame_start(fs_s)
  );
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs && n < 60);
    if (!fs) begin
      checks++;
      errors++;
      $display("FAIL wait_fs: frame_start absent after %0d cycles, required within 20", n);
    end
  endtask
  task automatic measure();
    w0 = 0; r0 = -1; w1 = 0; ws = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (pwm[0] ^ invert[0]) begin
        w0++;
        if (r0 < 0) r0 = k;
      end
      if (pwm[1] ^ invert[1]) w1++;
      if (pwm_s[0] ^ invert[0]) ws++;
    end
  endtask
  task automatic load(input int ch, input int dc, input bit slew);
    dc_in[ch*3 +: 3] = 3'(dc);
    if (slew) dc_load_s[ch] = 1'b1;
    else      dc_load[ch] = 1'b1;
    @(negedge clk);
    dc_load = '0;
    dc_load_s = '0;
  endtask
  task automatic first_frame(output int n, output int act);
    n = 0; act = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      dc_load = '0;
      dc_load_s = '0;
      if (fs) break;
      if ((pwm ^ invert) != 2'b00 || (pwm_s ^ invert) != 2'b00) act++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    invert = 2'b00;
    repeat (3) @(negedge clk);
    checks++; if (pwm !== 2'b00) begin errors++; $display("FAIL reset_pwm: got %b required 00", pwm); end
    checks++; if (pwm_s !== 2'b00) begin errors++; $display("FAIL reset_pwm_s: got %b required 00", pwm_s); end
    checks++; if (fs !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b required 0", fs); end
  endtask
  task automatic test_basic();
    int n, act;
    rst = 1'b0;
    en = 2'b01;
    dc_in[2:0] = 3'd3;
    dc_load = 2'b01;
    first_frame(n, act);
    checks++; if (n !== 20) begin errors++; $display("FAIL basic_first_fs: got %0d required 20", n); end
    checks++; if (act !== 0) begin errors++; $display("FAIL basic_frame1_idle: got %0d active cycles required 0", act); end
    measure();
    checks++; if (w0 !== 10) begin errors++; $display("FAIL basic_width: got %0d required 10", w0); end
    checks++; if (r0 !== 1) begin errors++; $display("FAIL basic_rise: got %0d required 1", r0); end
    checks++; if (w1 !== 0) begin errors++; $display("FAIL basic_ch1_idle: got %0d required 0", w1); end
    wait_fs(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL basic_period: got %0d required 1 after 19", n); end
  endtask
  task automatic test_clamp();
    int n;
    load(0, 7, 1'b0);
    wait_fs(n);
    measure();
    checks++; if (w0 !== 12) begin errors++; $display("FAIL clamp_high: got %0d required 12", w0); end
    wait_fs(n);
    load(0, 0, 1'b0);
    wait_fs(n);
    measure();
    checks++; if (w0 !== 4) begin errors++; $display("FAIL clamp_zero: got %0d required 4", w0); end
  endtask
  task automatic test_slew();
    int n;
    int up_exp[5] = '{6, 8, 10, 12, 12};
    int dn_exp[5] = '{10, 8, 6, 4, 4};
    wait_fs(n);
    load(0, 4, 1'b1);
    for (int f = 0; f < 5; f++) begin
      wait_fs(n);
      measure();
      checks++; if (ws !== up_exp[f]) begin errors++; $display("FAIL slew_up_%0d: got %0d required %0d", f, ws, up_exp[f]); end
    end
    wait_fs(n);
    load(0, 0, 1'b1);
    for (int f = 0; f < 5; f++) begin
      wait_fs(n);
      measure();
      checks++; if (ws !== dn_exp[f]) begin errors++; $display("FAIL slew_dn_%0d: got %0d required %0d", f, ws, dn_exp[f]); end
    end
  endtask
  task automatic test_invert();
    int n, act;
    invert = 2'b11;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (pwm !== 2'b11) begin errors++; $display("FAIL inv_reset_pwm: got %b required 11", pwm); end
    checks++; if (pwm_s !== 2'b11) begin errors++; $display("FAIL inv_reset_pwm_s: got %b required 11", pwm_s); end
    checks++; if (fs !== 1'b0) begin errors++; $display("FAIL inv_reset_fs: got %b required 0", fs); end
    rst = 1'b0;
    en = 2'b01;
    dc_in[2:0] = 3'd2;
    dc_load = 2'b01;
    first_frame(n, act);
    checks++; if (n !== 20) begin errors++; $display("FAIL inv_first_fs: got %0d required 20", n); end
    checks++; if (act !== 0) begin errors++; $display("FAIL inv_frame1_idle: got %0d required 0", act); end
    for (int f = 0; f < 2; f++) begin
      if (f > 0) wait_fs(n);
      measure();
      checks++; if (w0 !== 8) begin errors++; $display("FAIL inv_low_pulse_%0d: got %0d required 8", f, w0); end
      checks++; if (w1 !== 0) begin errors++; $display("FAIL inv_ch1_high_%0d: got %0d low cycles required 0", f, w1); end
    end
  endtask
  task automatic test_back_to_back();
    int n;
    wait_fs(n);
    load(0, 1, 1'b0);
    wait_fs(n);
    measure();
    checks++; if (w0 !== 6) begin errors++; $display("FAIL fbload_pre: got %0d required 6", w0); end
    dc_in[2:0] = 3'd4;
    dc_load = 2'b01;
    @(negedge clk);
    dc_load = 2'b00;
    checks++; if (fs !== 1'b1) begin errors++; $display("FAIL fbload_on_fb: got %b required 1", fs); end
    measure();
    checks++; if (w0 !== 6) begin errors++; $display("FAIL fbload_same_frame: got %0d required 6", w0); end
    wait_fs(n);
    measure();
    checks++; if (w0 !== 12) begin errors++; $display("FAIL fbload_next_frame: got %0d required 12", w0); end
  endtask
  task automatic test_reset_mid();
    int n, act;
    wait_fs(n);
    repeat (3) @(negedge clk);
    checks++; if ((pwm[0] ^ invert[0]) !== 1'b1) begin errors++; $display("FAIL mid_pulse_active: got %b required 1", pwm[0] ^ invert[0]); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (pwm !== invert) begin errors++; $display("FAIL mid_reset_pwm: got %b required %b", pwm, invert); end
    checks++; if (fs !== 1'b0) begin errors++; $display("FAIL mid_reset_fs: got %b required 0", fs); end
    rst = 1'b0;
    first_frame(n, act);
    checks++; if (n !== 20) begin errors++; $display("FAIL mid_first_fs: got %0d required 20", n); end
    checks++; if (act !== 0) begin errors++; $display("FAIL mid_frame1_idle: got %0d required 0", act); end
    measure();
    checks++; if (w0 !== 4) begin errors++; $display("FAIL mid_cleared_target: got %0d required 4", w0); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_slew();
    test_invert();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
